pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Issue/stall controller for the pipelined Y86-64 core. It sits between the decode stage and the pipeline registers. It keeps a 3-deep scoreboard of in-flight destination registers (E, M, W), compares it against decode's srcA/srcB, and sequences ret-wait, misprediction recovery and halt. Outputs drive the F/D/E pipeline-register stall and bubble controls.

Parameters:
FWD, 1, 1 = forwarding paths present (only load/use stalls); 0 = any RAW hit in E/M/W stalls
RET_WAIT_CYC, 3, cycles fetch is held after a ret issues (range 1-7)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
D_valid  in  1  D register holds a real instruction
D_icode  in  4  icode of instruction in D
d_srcA  in  4  decoded srcA (15 = none)
d_srcB  in  4  decoded srcB (15 = none)
d_dstE  in  4  decoded dstE (15 = none)
d_dstM  in  4  decoded dstM (15 = none)
e_mispredict  in  1  jXX in E resolved opposite to prediction
F_stall  out  1  hold fetch PC register
D_stall  out  1  hold D pipeline register
D_bubble  out  1  load nop into D
E_bubble  out  1  load nop into E
issue  out  1  instruction in D advances to E this cycle
sb_pending  out  16  bit r set if register r is a pending dstE/dstM in E/M/W; bit 15 always 0
halted  out  1  controller in HALTED state

Behaviour:
- State: mode in {RUN, RET_WAIT, HALTED}; ret_cnt 3 bits; scoreboard slots SE, SM, SW, each {dstE, dstM}, 4 bits apiece.
- Reset (clk edge with reset=1): mode=RUN, ret_cnt=0, all slot fields=15.
- While reset=1, outputs are forced: F_stall=0, D_stall=0, D_bubble=1, E_bubble=1, issue=0, sb_pending=0, halted=0.
- Outputs are combinational from registered state plus current inputs. issue has zero-cycle latency.
- Hit test hit(r):
  - r==15 never hits.
  - FWD=1: hit if r==SE.dstM.
  - FWD=0: hit if r equals any of the six slot fields.
- hz = D_valid & (hit(d_srcA) | hit(d_srcB)).
- Per-cycle priority, highest first:
  1. HALTED: F_stall=1, D_bubble=1, E_bubble=1, issue=0. Leaves only on reset.
  2. e_mispredict=1, any non-HALTED mode: D_bubble=1, E_bubble=1, F_stall=0, issue=0. Next mode=RUN, ret_cnt=0; this cancels a pending RET_WAIT.
  3. RET_WAIT: F_stall=1, D_bubble=1, issue=0. ret_cnt decrements each cycle; mode returns to RUN on the edge where ret_cnt goes 1->0.
  4. hz: F_stall=1, D_stall=1, E_bubble=1, issue=0.
  5. Otherwise: issue=D_valid; all other controls 0.
- On an issue edge:
  - D_icode==9 (ret): mode=RET_WAIT, ret_cnt=RET_WAIT_CYC.
  - D_icode==0 (halt): mode=HALTED.
- Scoreboard shifts every non-reset edge, including stall cycles: SW<=SM, SM<=SE. SE<= issue ? {d_dstE, d_dstM} : {15, 15}.
- sb_pending[r]=1 iff r<15 and r appears in any slot field, for all six fields regardless of FWD.
- A hazard therefore clears by itself: with FWD=0, at most 3 stall cycles; with FWD=1, exactly 1.
- Illegal icodes (>11) are treated like nop for sequencing. Their dst fields are still recorded as given.

Test Plan:
- Reset then D_valid=1, nop stream (all regs 15) -> issue=1 every cycle; F_stall/D_stall/bubbles 0; sb_pending=0.
- FWD=0: irmovq dstE=3 issues, next instr srcA=3 -> D_stall=F_stall=E_bubble=1 for 3 cycles, issue on 4th; sb_pending[3]=1 for 3 cycles.
- FWD=1: mrmovq dstM=2, then addq srcA=2 -> exactly 1 stall cycle, then issue=1. Same pair with dstE=2 instead (no dstM) -> no stall.
- ret issues (D_icode=9) -> next 3 cycles F_stall=1, D_bubble=1, issue=0; 4th cycle issue=1.
- ret issues, then e_mispredict=1 on the following cycle -> that cycle D_bubble=E_bubble=1, F_stall=0; next cycle mode RUN, normal issue.
- halt issues -> halted=1, F_stall=1, bubbles held indefinitely. Assert reset for 1 cycle mid-HALTED -> RUN, scoreboard 15s, issue resumes.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 issue/stall controller: 3-deep destination scoreboard (E/M/W),
// RAW hazard detection and ret-wait / mispredict / halt sequencing.
module pipe_hazard_ctrl #(
    parameter int FWD          = 1,
    parameter int RET_WAIT_CYC = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_valid,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  d_dstE,
    input  logic [3:0]  d_dstM,
    input  logic        e_mispredict,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        issue,
    output logic [15:0] sb_pending,
    output logic        halted
);

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_RET  = 4'h9;
    localparam logic [2:0] RET_CNT_INIT = 3'(RET_WAIT_CYC);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        HALTED   = 2'd2
    } mode_t;

    mode_t       r_mode;
    mode_t       w_mode_nxt;
    logic [2:0]  r_ret_cnt;
    logic [2:0]  w_ret_cnt_nxt;

    logic [3:0]  r_se_e, r_se_m, r_sm_e, r_sm_m, r_sw_e, r_sw_m;

    logic        w_hit_a;
    logic        w_hit_b;
    logic        w_hz;
    logic [15:0] w_pend;

    // With forwarding only a load still in E (its dstM) cannot be bypassed.
    function automatic logic f_hit(
        input logic [3:0] r,
        input logic [3:0] se_e, input logic [3:0] se_m,
        input logic [3:0] sm_e, input logic [3:0] sm_m,
        input logic [3:0] sw_e, input logic [3:0] sw_m
    );
        logic h;
        if (r == RNONE) begin
            h = 1'b0;
        end else if (FWD != 0) begin
            h = (r == se_m);
        end else begin
            h = (r == se_e) || (r == se_m) || (r == sm_e) ||
                (r == sm_m) || (r == sw_e) || (r == sw_m);
        end
        return h;
    endfunction

    always_comb begin
        w_hit_a = f_hit(d_srcA, r_se_e, r_se_m, r_sm_e, r_sm_m, r_sw_e, r_sw_m);
        w_hit_b = f_hit(d_srcB, r_se_e, r_se_m, r_sm_e, r_sm_m, r_sw_e, r_sw_m);
        w_hz    = D_valid && (w_hit_a || w_hit_b);
    end

    always_comb begin
        logic [3:0] w_fields [6];
        w_fields[0] = r_se_e;
        w_fields[1] = r_se_m;
        w_fields[2] = r_sm_e;
        w_fields[3] = r_sm_m;
        w_fields[4] = r_sw_e;
        w_fields[5] = r_sw_m;
        w_pend = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (w_fields[i] != RNONE) begin
                w_pend[w_fields[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        F_stall       = 1'b0;
        D_stall       = 1'b0;
        D_bubble      = 1'b0;
        E_bubble      = 1'b0;
        issue         = 1'b0;
        sb_pending    = w_pend;
        halted        = (r_mode == HALTED);
        w_mode_nxt    = r_mode;
        w_ret_cnt_nxt = r_ret_cnt;

        if (reset) begin
            D_bubble   = 1'b1;
            E_bubble   = 1'b1;
            sb_pending = '0;
            halted     = 1'b0;
        end else if (r_mode == HALTED) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
        end else if (e_mispredict) begin
            D_bubble      = 1'b1;
            E_bubble      = 1'b1;
            w_mode_nxt    = RUN;
            w_ret_cnt_nxt = '0;
        end else if (r_mode == RET_WAIT) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            if (r_ret_cnt <= 3'd1) begin
                w_mode_nxt    = RUN;
                w_ret_cnt_nxt = '0;
            end else begin
                w_ret_cnt_nxt = r_ret_cnt - 3'd1;
            end
        end else if (w_hz) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
        end else begin
            issue = D_valid;
            if (D_valid && D_icode == IC_RET) begin
                w_mode_nxt    = RET_WAIT;
                w_ret_cnt_nxt = RET_CNT_INIT;
            end else if (D_valid && D_icode == IC_HALT) begin
                w_mode_nxt = HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode    <= RUN;
            r_ret_cnt <= '0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_ret_cnt <= w_ret_cnt_nxt;
        end
    end

    // Scoreboard shifts every cycle, so stalls age hazards out on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_se_e <= RNONE;
            r_se_m <= RNONE;
            r_sm_e <= RNONE;
            r_sm_m <= RNONE;
            r_sw_e <= RNONE;
            r_sw_m <= RNONE;
        end else begin
            r_sw_e <= r_sm_e;
            r_sw_m <= r_sm_m;
            r_sm_e <= r_se_e;
            r_sm_m <= r_se_m;
            r_se_e <= issue ? d_dstE : RNONE;
            r_se_m <= issue ? d_dstM : RNONE;
        end
    end

endmodule
